// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - round-robin frame scheduler sharing one serial FFT core
// Grants whole frames, forwards the granted stream to the core and tags core output by source channel.
module fft_frame_scheduler #(
    parameter int N_POINT        = 32,
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int NUM_REQ        = 2,
    parameter int MAX_INFLIGHT   = 2,
    localparam int CHW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [DATA_IN_WIDTH-1:0]          fft_data_in,
    output logic                              fft_data_in_valid,
    input  logic [DATA_OUT_WIDTH-1:0]         fft_data_out,
    input  logic                              fft_data_out_valid,
    output logic [DATA_OUT_WIDTH-1:0]         out_data,
    output logic                              out_valid,
    output logic [CHW-1:0]                    out_chan,
    output logic                              out_last,
    output logic                              busy,
    output logic                              gap_err,
    output logic                              orphan_err
);
    localparam int CW = $clog2(N_POINT) + 1;
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                       state_q;
    logic [CHW-1:0]               rr_ptr_q;
    logic [CHW-1:0]               grant_q;
    logic [CW-1:0]                in_cnt_q;
    logic [CW-1:0]                out_cnt_q;
    logic [IW-1:0]                inflight_q;
    logic [PW-1:0]                wr_ptr_q;
    logic [PW-1:0]                rd_ptr_q;
    logic [CHW-1:0]               tag_q [MAX_INFLIGHT];
    logic [NUM_REQ-1:0]           req_ready_q;
    logic [DATA_IN_WIDTH-1:0]     fft_data_in_q;
    logic                         fft_data_in_valid_q;
    logic [DATA_OUT_WIDTH-1:0]    out_data_q;
    logic                         out_valid_q;
    logic [CHW-1:0]               out_chan_q;
    logic                         out_last_q;
    logic                         gap_err_q;
    logic                         orphan_err_q;

    logic [DATA_IN_WIDTH-1:0]     req_word [NUM_REQ];
    logic                         sel_found;
    logic [CHW-1:0]               sel_idx;
    logic [CHW-1:0]               cand;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic                         fifo_empty;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DATA_IN_WIDTH +: DATA_IN_WIDTH];
    end

    // Scan downward so the requester closest to rr_ptr is the one left selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = CHW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign fifo_empty = (inflight_q == '0);
    assign accept     = (state_q == STREAM) && req_valid[grant_q] && req_ready_q[grant_q];
    assign push       = (state_q == IDLE) && sel_found && (inflight_q < IW'(MAX_INFLIGHT));
    assign pop        = fft_data_out_valid && !fifo_empty && (out_cnt_q == CW'(N_POINT - 1));

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_q             <= '0;
            in_cnt_q            <= '0;
            out_cnt_q           <= '0;
            inflight_q          <= '0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) tag_q[i] <= '0;
            req_ready_q         <= '0;
            fft_data_in_q       <= '0;
            fft_data_in_valid_q <= 1'b0;
            out_data_q          <= '0;
            out_valid_q         <= 1'b0;
            out_chan_q          <= '0;
            out_last_q          <= 1'b0;
            gap_err_q           <= 1'b0;
            orphan_err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        grant_q     <= sel_idx;
                        req_ready_q <= NUM_REQ'(1) << sel_idx;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (in_cnt_q == CW'(N_POINT - 1)) begin
                            in_cnt_q    <= '0;
                            rr_ptr_q    <= (grant_q == CHW'(NUM_REQ - 1)) ? '0 : grant_q + CHW'(1);
                            req_ready_q <= '0;
                            state_q     <= IDLE;
                        end else begin
                            in_cnt_q <= in_cnt_q + CW'(1);
                        end
                    end else if (in_cnt_q != '0) begin
                        gap_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            fft_data_in_valid_q <= accept;
            if (accept) fft_data_in_q <= req_word[grant_q];

            if (push) begin
                tag_q[wr_ptr_q] <= sel_idx;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end

            // Untagged core output is still forwarded, but flagged and not counted.
            out_valid_q <= fft_data_out_valid;
            out_last_q  <= pop;
            if (fft_data_out_valid) begin
                out_data_q <= fft_data_out;
                if (fifo_empty) begin
                    orphan_err_q <= 1'b1;
                    out_chan_q   <= '0;
                end else begin
                    out_chan_q <= tag_q[rd_ptr_q];
                    out_cnt_q  <= pop ? '0 : out_cnt_q + CW'(1);
                end
            end
            if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);

            if (push && !pop) inflight_q <= inflight_q + IW'(1);
            else if (pop && !push) inflight_q <= inflight_q - IW'(1);
        end
    end

    assign req_ready         = req_ready_q;
    assign fft_data_in       = fft_data_in_q;
    assign fft_data_in_valid = fft_data_in_valid_q;
    assign out_data          = out_data_q;
    assign out_valid         = out_valid_q;
    assign out_chan          = out_chan_q;
    assign out_last          = out_last_q;
    assign busy              = (state_q != IDLE) || (inflight_q != '0);
    assign gap_err           = gap_err_q;
    assign orphan_err        = orphan_err_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - directed scenario bench for fft_frame_scheduler
// Requesters, a delay-line core model and output logging all advance in one tick task.
module tb_fft_frame_scheduler;
    logic        clk;
    logic        rst;
    logic [31:0] req_data;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] fft_data_in;
    logic        fft_data_in_valid;
    logic [31:0] fft_data_out;
    logic        fft_data_out_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic [0:0]  out_chan;
    logic        out_last;
    logic        busy;
    logic        gap_err;
    logic        orphan_err;

    fft_frame_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .req_data           (req_data),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .fft_data_in        (fft_data_in),
        .fft_data_in_valid  (fft_data_in_valid),
        .fft_data_out       (fft_data_out),
        .fft_data_out_valid (fft_data_out_valid),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_chan           (out_chan),
        .out_last           (out_last),
        .busy               (busy),
        .gap_err            (gap_err),
        .orphan_err         (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   cnt [2];
    int   limit [2];
    int   gap_at [2];
    int   gap_left [2];
    int   first_v [2];
    bit   seen_v [2];
    bit   req_on [2];
    logic [1:0] pend;
    logic [1:0] prev_ready;

    int   core_delay;
    bit   core_manual;
    logic man_v;
    logic [31:0] man_d;
    logic        hist_v [512];
    logic [15:0] hist_d [512];

    logic [15:0] in_q [$];
    int          in_cyc [$];
    logic [31:0] od_q [$];
    logic [0:0]  oc_q [$];
    logic        ol_q [$];
    int          g_q [$];
    int          g_cyc [$];
    int          first_last;

    task automatic tick();
        bit v;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            pend = '0;
            for (int j = 0; j < 512; j++) hist_v[j] = 1'b0;
        end
        for (int i = 0; i < 2; i++) if (pend[i]) cnt[i]++;
        if (fft_data_in_valid) begin
            in_q.push_back(fft_data_in);
            in_cyc.push_back(cyc);
        end
        if (out_valid) begin
            od_q.push_back(out_data);
            oc_q.push_back(out_chan);
            ol_q.push_back(out_last);
            if (out_last && first_last < 0) first_last = cyc;
        end
        if (req_ready != 2'b00 && prev_ready == 2'b00) begin
            g_q.push_back(req_ready[1] ? 1 : 0);
            g_cyc.push_back(cyc);
        end
        prev_ready = req_ready;
        hist_v[cyc % 512] = fft_data_in_valid;
        hist_d[cyc % 512] = fft_data_in;
        if (core_manual) begin
            fft_data_out_valid = man_v;
            fft_data_out       = man_d;
        end else if (cyc >= core_delay) begin
            fft_data_out_valid = hist_v[(cyc - core_delay) % 512];
            fft_data_out       = {16'h0, hist_d[(cyc - core_delay) % 512]};
        end else begin
            fft_data_out_valid = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            v = req_on[i] && (cnt[i] < limit[i]);
            if (v && cnt[i] == gap_at[i] && gap_left[i] > 0) begin
                v = 1'b0;
                gap_left[i]--;
            end
            req_valid[i] = v;
            req_data[i*16 +: 16] = 16'(i * 1000 + cnt[i] + 1);
            if (v && !seen_v[i]) begin
                seen_v[i]  = 1'b1;
                first_v[i] = cyc;
            end
        end
        pend = req_valid & req_ready;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; limit[i] = 0; gap_at[i] = -1; gap_left[i] = 0;
            first_v[i] = -1; seen_v[i] = 1'b0; req_on[i] = 1'b0;
        end
        pend = '0;
        in_q.delete(); in_cyc.delete(); od_q.delete(); oc_q.delete(); ol_q.delete();
        g_q.delete(); g_cyc.delete();
        first_last = -1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_logs();
        core_manual = 1'b0;
        man_v = 1'b0;
        core_delay = 10;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({req_ready, fft_data_in_valid, out_valid, out_chan, out_last, busy, gap_err, orphan_err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {req_ready, fft_data_in_valid, out_valid, out_chan, out_last, busy, gap_err, orphan_err});
        end
        checks++;
        if (fft_data_in !== 16'h0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got in=%0h out=%0h expected 0", fft_data_in, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        int bad;
        int lasts;
        apply_reset();
        req_on[0] = 1'b1;
        limit[0]  = 32;
        for (int n = 0; n < 300 && od_q.size() < 32; n++) tick();
        checks++;
        if (od_q.size() != 32 || in_q.size() != 32) begin
            errors++;
            $display("FAIL single_count: got out=%0d in=%0d expected 32", od_q.size(), in_q.size());
        end
        if (in_q.size() == 32 && od_q.size() == 32) begin
            bad = 0;
            for (int j = 0; j < 32; j++) if (in_q[j] !== 16'(j + 1)) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL single_in_data: got %0d bad samples expected 0", bad); end
            checks++;
            if (in_cyc[31] - in_cyc[0] != 31) begin
                errors++; $display("FAIL single_contig: got span %0d expected 31", in_cyc[31] - in_cyc[0]);
            end
            checks++;
            if (in_cyc[0] != first_v[0] + 2) begin
                errors++; $display("FAIL single_latency: got %0d expected %0d", in_cyc[0], first_v[0] + 2);
            end
            bad = 0; lasts = 0;
            for (int j = 0; j < 32; j++) begin
                if (od_q[j] !== 32'(j + 1) || oc_q[j] !== 1'b0) bad++;
                if (ol_q[j] === 1'b1) lasts++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL single_out: got %0d bad samples expected 0", bad); end
            checks++;
            if (lasts != 1 || ol_q[31] !== 1'b1) begin
                errors++; $display("FAIL single_last: got %0d lasts, last31=%b expected 1,1", lasts, ol_q[31]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_on[0] = 1'b1; req_on[1] = 1'b1;
        limit[0]  = 64;   limit[1]  = 64;
        for (int n = 0; n < 600 && od_q.size() < 128; n++) tick();
        checks++;
        if (g_q.size() != 4 || od_q.size() != 128 || in_q.size() != 128) begin
            errors++;
            $display("FAIL rr_count: got grants=%0d out=%0d in=%0d expected 4,128,128", g_q.size(), od_q.size(), in_q.size());
        end
        if (g_q.size() == 4 && od_q.size() == 128 && in_q.size() == 128) begin
            checks++;
            if (g_q[0] != 0 || g_q[1] != 1 || g_q[2] != 0 || g_q[3] != 1) begin
                errors++; $display("FAIL rr_order: got %0d%0d%0d%0d expected 0101", g_q[0], g_q[1], g_q[2], g_q[3]);
            end
            checks++;
            if (g_cyc[1] - g_cyc[0] != 33 || g_cyc[3] - g_cyc[2] != 33) begin
                errors++; $display("FAIL rr_spacing: got %0d,%0d expected 33", g_cyc[1] - g_cyc[0], g_cyc[3] - g_cyc[2]);
            end
            checks++;
            if (in_cyc[32] - in_cyc[31] != 2) begin
                errors++; $display("FAIL rr_hole: got %0d expected 2", in_cyc[32] - in_cyc[31]);
            end
            checks++;
            if (in_q[32] !== 16'd1001 || in_q[64] !== 16'd33 || in_q[127] !== 16'd1064) begin
                errors++; $display("FAIL rr_data: got %0d,%0d,%0d expected 1001,33,1064", in_q[32], in_q[64], in_q[127]);
            end
            checks++;
            if ({oc_q[0], oc_q[31], oc_q[32], oc_q[63], oc_q[64], oc_q[96], oc_q[127]} !== 7'b0011011) begin
                errors++; $display("FAIL rr_tags: got %b expected 0011011", {oc_q[0], oc_q[31], oc_q[32], oc_q[63], oc_q[64], oc_q[96], oc_q[127]});
            end
        end
    endtask

    task automatic test_inflight_limit();
        apply_reset();
        core_delay = 200;
        req_on[0] = 1'b1; req_on[1] = 1'b1;
        limit[0]  = 96;   limit[1]  = 96;
        for (int n = 0; n < 800 && g_q.size() < 3; n++) tick();
        checks++;
        if (g_q.size() != 3 || first_last < 0) begin
            errors++; $display("FAIL inflight_count: got grants=%0d last=%0d expected 3,>=0", g_q.size(), first_last);
        end
        if (g_q.size() == 3 && first_last >= 0) begin
            checks++;
            if (g_cyc[2] != first_last + 1) begin
                errors++; $display("FAIL inflight_release: got %0d expected %0d", g_cyc[2], first_last + 1);
            end
            checks++;
            if (first_last != g_cyc[0] + 233) begin
                errors++; $display("FAIL inflight_pop_time: got %0d expected %0d", first_last, g_cyc[0] + 233);
            end
            checks++;
            if (g_q[2] != 0 || g_cyc[1] - g_cyc[0] != 33) begin
                errors++; $display("FAIL inflight_third: got req=%0d spacing=%0d expected 0,33", g_q[2], g_cyc[1] - g_cyc[0]);
            end
        end
    endtask

    task automatic test_gap();
        int bad;
        apply_reset();
        req_on[1]   = 1'b1;
        limit[1]    = 32;
        gap_at[1]   = 10;
        gap_left[1] = 3;
        for (int n = 0; n < 300 && od_q.size() < 32; n++) tick();
        checks++;
        if (gap_err !== 1'b1) begin errors++; $display("FAIL gap_flag: got %b expected 1", gap_err); end
        checks++;
        if (in_q.size() != 32 || od_q.size() != 32) begin
            errors++; $display("FAIL gap_count: got in=%0d out=%0d expected 32", in_q.size(), od_q.size());
        end
        if (in_q.size() == 32 && od_q.size() == 32) begin
            checks++;
            if (in_cyc[10] - in_cyc[9] != 4 || in_cyc[31] - in_cyc[0] != 34) begin
                errors++; $display("FAIL gap_hole: got %0d,%0d expected 4,34", in_cyc[10] - in_cyc[9], in_cyc[31] - in_cyc[0]);
            end
            bad = 0;
            for (int j = 0; j < 32; j++) begin
                if (in_q[j] !== 16'(1001 + j) || oc_q[j] !== 1'b1) bad++;
                if (ol_q[j] !== (j == 31)) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL gap_frame: got %0d bad samples expected 0", bad); end
        end
    endtask

    task automatic test_orphan();
        apply_reset();
        core_manual = 1'b1;
        man_d = 32'hABCD;
        man_v = 1'b1;
        tick();
        man_v = 1'b0;
        tick();
        checks++;
        if ({out_valid, orphan_err, out_chan, out_last} !== 4'b1100 || out_data !== 32'hABCD) begin
            errors++;
            $display("FAIL orphan_out: got v/err/chan/last=%b data=%0h expected 1100 abcd", {out_valid, orphan_err, out_chan, out_last}, out_data);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || orphan_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL orphan_after: got busy=%b err=%b v=%b expected 0,1,0", busy, orphan_err, out_valid);
        end
        core_manual = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        apply_reset();
        req_on[0] = 1'b1;
        limit[0]  = 32;
        for (int n = 0; n < 100 && cnt[0] < 15; n++) tick();
        checks++;
        if (cnt[0] != 15 || busy !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got cnt=%0d busy=%b expected 15,1", cnt[0], busy);
        end
        rst = 1'b1;
        req_on[0] = 1'b0;
        tick();
        checks++;
        if ({req_ready, fft_data_in_valid, out_valid, out_chan, out_last, busy, gap_err, orphan_err} !== 10'b0
            || fft_data_in !== 16'h0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL midrst_clear: got ctrl=%b in=%0h out=%0h expected 0", {req_ready, fft_data_in_valid, out_valid, out_chan, out_last, busy, gap_err, orphan_err}, fft_data_in, out_data);
        end
        rst = 1'b0;
        clear_logs();
        req_on[1] = 1'b1;
        limit[1]  = 32;
        for (int n = 0; n < 300 && od_q.size() < 32; n++) tick();
        checks++;
        if (od_q.size() != 32 || in_q.size() != 32 || g_q.size() != 1) begin
            errors++; $display("FAIL midrst_count: got out=%0d in=%0d grants=%0d expected 32,32,1", od_q.size(), in_q.size(), g_q.size());
        end
        if (od_q.size() == 32 && in_q.size() == 32 && g_q.size() == 1) begin
            bad = 0;
            for (int j = 0; j < 32; j++) begin
                if (in_q[j] !== 16'(1001 + j) || od_q[j] !== 32'(1001 + j) || oc_q[j] !== 1'b1) bad++;
                if (ol_q[j] !== (j == 31)) bad++;
            end
            checks++;
            if (bad != 0 || g_q[0] != 1) begin
                errors++; $display("FAIL midrst_frame: got %0d bad, grant=%0d expected 0,1", bad, g_q[0]);
            end
        end
        checks++;
        if (orphan_err !== 1'b0 || gap_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_flags: got orphan=%b gap=%b busy=%b expected 0,0,0", orphan_err, gap_err, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_data = '0;
        req_valid = '0;
        fft_data_out = '0;
        fft_data_out_valid = 1'b0;
        prev_ready = '0;
        core_delay = 10;
        core_manual = 1'b0;
        man_v = 1'b0;
        man_d = '0;
        for (int j = 0; j < 512; j++) begin hist_v[j] = 1'b0; hist_d[j] = '0; end
        clear_logs();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_inflight_limit();
        test_gap();
        test_orphan();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
